// File: rtl/tdc_pulse_gen.sv
// Start/stop stimulus generator for TDC calibration and self-test.
// Byte-loaded config; trigger launches start/stop bursts with a fixed gap.
module tdc_pulse_gen #(
  parameter int GAP   = 4,
  parameter int CNT_W = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_en,
  input  logic [1:0] load_sel,
  input  logic [7:0] load_data,
  input  logic       trig,
  input  logic       abort,
  output logic       start_out,
  output logic       stop_out,
  output logic       busy,
  output logic       done
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_GAP
  } state_t;

  state_t           r_state;
  state_t           w_nstate;
  logic [31:0]      r_cfg;
  logic             r_trig_d;
  logic [CNT_W-1:0] r_t;
  logic [CNT_W-1:0] w_nt;
  logic [15:0]      r_ds;
  logic [7:0]       r_ws;
  logic [7:0]       r_rs;
  logic [GW-1:0]    r_gcnt;
  logic             r_start;
  logic             r_stop;
  logic             r_busy;
  logic             r_done;

  logic             w_edge;
  logic [15:0]      w_ds;
  logic [7:0]       w_ws;
  logic [CNT_W-1:0] w_len;
  logic             w_last;
  logic             w_gap_end;
  logic             w_start_n;
  logic             w_stop_n;
  logic             w_busy_n;
  logic             w_done_n;

  assign start_out = r_start;
  assign stop_out  = r_stop;
  assign busy      = r_busy;
  assign done      = r_done;

  // abort in the trigger cycle suppresses the launch
  assign w_edge = trig & ~r_trig_d & (r_state == S_IDLE) & ~abort;

  assign w_ds = !w_edge ? r_ds :
                (r_cfg[15:0] == 16'd0) ? 16'd1 : r_cfg[15:0];
  assign w_ws = !w_edge ? r_ws :
                (r_cfg[23:16] == 8'd0) ? 8'd1 : r_cfg[23:16];

  assign w_len     = CNT_W'(r_ds) + CNT_W'(r_ws);
  assign w_last    = (r_t == w_len - CNT_W'(1));
  assign w_gap_end = (r_gcnt == GW'(GAP - 1));

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nstate;
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_nt     = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_edge) w_nstate = S_BURST;
      end
      S_BURST: begin
        if (abort)       w_nstate = S_IDLE;
        else if (w_last) w_nstate = (r_rs != 8'd0) ? S_GAP : S_IDLE;
        else             w_nt     = r_t + CNT_W'(1);
      end
      S_GAP: begin
        if (abort)          w_nstate = S_IDLE;
        else if (w_gap_end) w_nstate = S_BURST;
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  // outputs are registered from the next-cycle timebase
  always_comb begin
    w_start_n = 1'b0;
    w_stop_n  = 1'b0;
    if (w_nstate == S_BURST) begin
      w_start_n = w_nt < CNT_W'(w_ws);
      w_stop_n  = (w_nt >= CNT_W'(w_ds)) &&
                  (w_nt < CNT_W'(w_ds) + CNT_W'(w_ws));
    end
    w_busy_n = (w_nstate != S_IDLE);
    w_done_n = (r_state == S_BURST) && !abort && w_last &&
               (r_rs == 8'd0);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_cfg    <= '0;
      r_trig_d <= 1'b0;
      r_t      <= '0;
      r_ds     <= '0;
      r_ws     <= '0;
      r_rs     <= '0;
      r_gcnt   <= '0;
      r_start  <= 1'b0;
      r_stop   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_trig_d <= trig;
      r_t      <= w_nt;
      r_ds     <= w_ds;
      r_ws     <= w_ws;
      r_start  <= w_start_n;
      r_stop   <= w_stop_n;
      r_busy   <= w_busy_n;
      r_done   <= w_done_n;
      if (load_en) begin
        unique case (load_sel)
          2'd0: r_cfg[7:0]   <= load_data;
          2'd1: r_cfg[15:8]  <= load_data;
          2'd2: r_cfg[23:16] <= load_data;
          2'd3: r_cfg[31:24] <= load_data;
          default: ;
        endcase
      end
      if (w_edge) begin
        r_rs <= r_cfg[31:24];
      end else if (r_state == S_BURST && !abort && w_last &&
                   r_rs != 8'd0) begin
        r_rs <= r_rs - 8'd1;
      end
      if (r_state == S_GAP && w_nstate == S_GAP) r_gcnt <= r_gcnt + GW'(1);
      else                                       r_gcnt <= '0;
    end
  end

endmodule

// File: tb/tb_tdc_pulse_gen.sv
// Directed bench for tdc_pulse_gen.
// Per-cycle output masks compared against hand-derived expectations.
module tb_tdc_pulse_gen;

  logic       clk;
  logic       rst_n;
  logic       load_en;
  logic [1:0] load_sel;
  logic [7:0] load_data;
  logic       trig;
  logic       abort;
  logic       start_out;
  logic       stop_out;
  logic       busy;
  logic       done;

  int n_chk;
  int n_err;

  logic [63:0] m_st;
  logic [63:0] m_sp;
  logic [63:0] m_by;
  logic [63:0] m_dn;

  tdc_pulse_gen #(.GAP(4), .CNT_W(17)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (load_en),
    .load_sel  (load_sel),
    .load_data (load_data),
    .trig      (trig),
    .abort     (abort),
    .start_out (start_out),
    .stop_out  (stop_out),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    load_en   = 1'b0;
    load_sel  = 2'd0;
    load_data = 8'd0;
    trig      = 1'b0;
    abort     = 1'b0;
    @(negedge clk);
    check("rst_out", {60'd0, start_out, stop_out, busy, done}, 64'd0);
    rst_n = 1'b0;
  endtask

  task automatic write_cfg(input logic [31:0] v);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      load_en   = 1'b1;
      load_sel  = 2'(i);
      load_data = v[8*i +: 8];
    end
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic run(input logic [63:0] trig_m,
                     input logic [63:0] abort_m,
                     input int          ld_c,
                     input logic [1:0]  ld_s,
                     input logic [7:0]  ld_d,
                     input int          n);
    m_st = '0;
    m_sp = '0;
    m_by = '0;
    m_dn = '0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      m_st[c]   = start_out;
      m_sp[c]   = stop_out;
      m_by[c]   = busy;
      m_dn[c]   = done;
      trig      = trig_m[c];
      abort     = abort_m[c];
      load_en   = (c == ld_c);
      load_sel  = ld_s;
      load_data = ld_d;
    end
  endtask

  task automatic cmp4(input string tag,
                      input logic [63:0] st,
                      input logic [63:0] sp,
                      input logic [63:0] by,
                      input logic [63:0] dn);
    check({tag, "_start"}, m_st, st);
    check({tag, "_stop"},  m_sp, sp);
    check({tag, "_busy"},  m_by, by);
    check({tag, "_done"},  m_dn, dn);
  endtask

  int st_c;
  int sp_c;
  int dn_c;
  int cc;

  initial begin
    n_chk     = 0;
    n_err     = 0;
    rst_n     = 1'b1;
    load_en   = 1'b0;
    load_sel  = 2'd0;
    load_data = 8'd0;
    trig      = 1'b0;
    abort     = 1'b0;

    // defaults: D=W=1, trig held high must not retrigger
    do_reset();
    run(rng(10, 19), '0, 0, 2'd0, 8'd0, 25);
    cmp4("dflt", rng(11, 11), rng(12, 12), rng(11, 12), rng(13, 13));

    // single burst, cfg rewritten to D=9 mid-sequence
    do_reset();
    write_cfg(32'h0002_0005);
    run(rng(10, 10) | rng(20, 20), '0, 13, 2'd0, 8'd9, 40);
    cmp4("single",
         rng(11, 12) | rng(21, 22),
         rng(16, 17) | rng(30, 31),
         rng(11, 17) | rng(21, 31),
         rng(18, 18) | rng(32, 32));

    // repeated bursts with ignored edges while busy
    do_reset();
    write_cfg(32'h0201_0003);
    run(rng(10, 10) | rng(15, 15) | rng(25, 25), '0, 0, 2'd0, 8'd0, 40);
    cmp4("repeat",
         rng(11, 11) | rng(19, 19) | rng(27, 27),
         rng(14, 14) | rng(22, 22) | rng(30, 30),
         rng(11, 30), rng(31, 31));

    // overlap, then abort+trigger in the same cycle, then a real edge
    do_reset();
    write_cfg(32'h0006_0002);
    run(rng(10, 10) | rng(25, 25) | rng(30, 30), rng(25, 25),
        0, 2'd0, 8'd0, 45);
    cmp4("overlap",
         rng(11, 16) | rng(31, 36),
         rng(13, 18) | rng(33, 38),
         rng(11, 18) | rng(31, 38),
         rng(19, 19) | rng(39, 39));

    // abort mid-burst, retrigger right after
    do_reset();
    write_cfg(32'h0201_0003);
    run(rng(10, 10) | rng(16, 16), rng(14, 14), 0, 2'd0, 8'd0, 45);
    cmp4("abort",
         rng(11, 11) | rng(17, 17) | rng(25, 25) | rng(33, 33),
         rng(14, 14) | rng(20, 20) | rng(28, 28) | rng(36, 36),
         rng(11, 14) | rng(17, 36),
         rng(37, 37));

    // asynchronous reset mid-burst clears outputs and cfg
    do_reset();
    write_cfg(32'h0006_0002);
    run(rng(10, 10), '0, 0, 2'd0, 8'd0, 13);
    rst_n = 1'b1;
    #1;
    check("arst_out", {61'd0, start_out, stop_out, busy}, 64'd0);
    @(negedge clk);
    trig  = 1'b0;
    rst_n = 1'b0;
    run(rng(10, 10), '0, 0, 2'd0, 8'd0, 20);
    cmp4("arst_cfg", rng(11, 11), rng(12, 12), rng(11, 12), rng(13, 13));

    // widest D and W
    do_reset();
    write_cfg(32'h00FF_FFFF);
    @(negedge clk);
    trig = 1'b1;
    cc   = 0;
    st_c = -1;
    sp_c = -1;
    dn_c = -1;
    while (dn_c < 0 && cc < 70000) begin
      @(negedge clk);
      cc++;
      trig = 1'b0;
      if (start_out && st_c < 0) st_c = cc;
      if (stop_out && sp_c < 0)  sp_c = cc;
      if (done && dn_c < 0)      dn_c = cc;
    end
    check("wide_start", 64'(st_c), 64'd1);
    check("wide_stop",  64'(sp_c), 64'd65536);
    check("wide_done",  64'(dn_c), 64'd65791);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/tdc_pulse_gen.md
Name: tdc_pulse_gen

Overview:
Programmable start/stop stimulus generator. It is the transmit-side counterpart of the TDC capture path. A host loads a 32-bit configuration word one byte at a time. On a trigger edge the block emits a start edge, then a stop edge a programmed number of clock cycles later, optionally repeated as a burst with a fixed gap. Its outputs drive the TDC start/delay inputs for on-chip calibration and self-test.

Parameters:
GAP, 4, idle cycles (all outputs low) between consecutive bursts; must be ≥1.
CNT_W, 17, width of the internal timebase counter; must hold 16-bit D plus 8-bit W.

Ports:
clk  in  1  system clock; all logic rising-edge.
rst_n  in  1  reset, asynchronous, active-high (rst_n=1 resets).
load_en  in  1  write strobe; writes load_data into byte lane load_sel this cycle.
load_sel  in  2  byte lane: 00=cfg[7:0], 01=cfg[15:8], 10=cfg[23:16], 11=cfg[31:24].
load_data  in  8  byte to write.
trig  in  1  trigger level, synchronous to clk; rising edge launches a sequence.
abort  in  1  synchronous abort of a running sequence.
start_out  out  1  registered start pulse.
stop_out  out  1  registered stop pulse.
busy  out  1  high while a sequence is active.
done  out  1  one-cycle pulse when a sequence completes normally.

Behaviour:
- Config word cfg[31:0]:
  - D = cfg[15:0], start-to-stop delay in cycles. D=0 is treated as 1.
  - W = cfg[23:16], pulse width in cycles. W=0 is treated as 1.
  - R = cfg[31:24], extra repeats. Total bursts = R+1.
- Reset:
  - cfg=0, start_out=0, stop_out=0, busy=0, done=0.
  - FSM=IDLE, trig_d=0, counters=0.
  - Reset takes effect immediately, including mid-sequence.
- cfg writes:
  - Accepted every cycle, including while busy.
  - A running sequence uses a snapshot (Ds, Ws, Rs) taken at trigger detection. Writes during a sequence affect only the next one.
- Trigger detection:
  - Edge at cycle k means trig=1 and trig_d=0 at edge k, with FSM=IDLE.
  - Edges while busy are ignored and not queued.
  - trig held high does not retrigger.
- States: IDLE -> BURST -> (GAP -> BURST)* -> IDLE.
- BURST:
  - Timebase t counts from 0 at cycle k+1 (first burst) or at the first cycle after GAP.
  - start_out=1 iff t<Ws.
  - stop_out=1 iff Ds≤t<Ds+Ws.
  - Start and stop may overlap when Ws>Ds; each is generated independently.
  - The burst ends after t=Ds+Ws-1.
  - If bursts remaining > 0: go to GAP for GAP cycles (outputs low, busy=1), then the next BURST.
  - Otherwise: go to IDLE.
- Burst n (0-based) has its start rising edge at cycle k+1+n·(Ds+Ws+GAP).
- busy=1 from cycle k+1 through the last stop cycle.
- done=1 for exactly one cycle: the first cycle after the final burst ends. busy=0 in that same cycle. A trigger edge in that cycle is accepted.
- Latency: trigger edge to start_out rise = 1 cycle. start rise to stop rise = Ds cycles.
- abort=1 in any non-IDLE state:
  - Next cycle: start_out=0, stop_out=0, busy=0, FSM=IDLE, no done pulse.
  - abort in IDLE has no effect.
  - abort and a trigger edge in the same cycle: abort wins, no sequence starts.
- Arithmetic:
  - Ds+Ws is computed in CNT_W bits with no overflow. The maximum is 65535+255.
  - The burst counter is 8 bits and counts down from Rs; it does not wrap.

Test Plan:
- Reset and defaults: assert rst_n, release, no cfg writes, trig edge at cycle 10 -> start_out high cycle 11 only, stop_out high cycle 12 only (D=W treated as 1), done at 13, busy high cycles 11-12.
- Single burst: cfg=0x0002_0005 via four byte writes, trig edge at cycle 10 -> start_out high 11-12, stop_out high 16-17, busy 11-17, done pulse at 18.
- Repeated burst: cfg=0x0201_0003, GAP=4, edge at 10 -> start rises at 11, 19, 27; stop high at 14, 22, 30; done at 31; trig edges at 15 and 25 ignored.
- Overlap and wide values: cfg=0x0006_0002 -> start high 11-16, stop high 13-18, both high 13-16. Separately cfg D=0xFFFF, W=0xFF -> stop rises at start+65535, done at start+65790.
- Config during busy: rewrite cfg to D=9 at cycle 13 of the first scenario -> the current stop still rises at 16; the next trigger uses D=9.
- Abort and reset mid-sequence:
  - abort at cycle 14 of the repeated burst -> all outputs 0 at 15, no done, a new trig edge at 16 is accepted.
  - rst_n pulse mid-burst -> outputs 0 asynchronously and cfg=0.
